// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parallel-in / serial-out transmitter.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  // Bit-counter width; clamped to 1 so a degenerate width still elaborates.
  function automatic int cnt_width(input int w);
    return (w <= 1) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Counts bits already sent within a word; flags the final bit position.
module ser_bit_counter
  import serializer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0] cnt_q;

  // Clear wins over enable so a reload on the final bit restarts at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt_q <= '0;
    else if (clr)           cnt_q <= '0;
    else if (en && !tc)     cnt_q <= cnt_q + CW'(1);
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/configurable_serializer.sv
// Word-in, bit-out transmitter with valid/ready on both sides and
// zero-bubble back-to-back words.
module configurable_serializer
  import serializer_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_data,
  output logic             ser_last,
  output logic             busy
);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] shift_q;
  logic             tc;
  logic             bit_acc, load_acc;

  assign ser_valid  = (state_q == SHIFT);
  assign busy       = (state_q == SHIFT);
  assign ser_last   = (state_q == SHIFT) && tc;
  assign ser_data   = (state_q == SHIFT) &&
                      (LSB_FIRST ? shift_q[0] : shift_q[WIDTH-1]);
  // Depends only on state and ser_ready, never on load_valid.
  assign load_ready = (state_q == IDLE) || (ser_ready && ser_last);

  assign bit_acc  = ser_valid && ser_ready;
  assign load_acc = load_valid && load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_valid) state_d = SHIFT;
      SHIFT:   if (bit_acc && tc && !load_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift toward the output end, zero-filling the vacated bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 shift_q <= '0;
    else if (load_acc)       shift_q <= load_data;
    else if (bit_acc && !tc) shift_q <= LSB_FIRST ? {1'b0, shift_q[WIDTH-1:1]}
                                                  : {shift_q[WIDTH-2:0], 1'b0};
  end

  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .en  (bit_acc),
    .clr (load_acc),
    .tc  (tc)
  );

endmodule

// File: tb/tb_configurable_serializer.sv
// Drives an MSB-first and an LSB-first serializer in lockstep and checks
// both against a queue-of-pending-bits reference model.
module tb_configurable_serializer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         ser_ready;

  logic lr_m, sv_m, sd_m, sl_m, bz_m;
  logic lr_l, sv_l, sd_l, sl_l, bz_l;

  int vectors    = 0;
  int miscompares = 0;

  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  configurable_serializer #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_m),
    .load_data(load_data), .ser_valid(sv_m), .ser_ready(ser_ready),
    .ser_data(sd_m), .ser_last(sl_m), .busy(bz_m)
  );

  configurable_serializer #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(lr_l),
    .load_data(load_data), .ser_valid(sv_l), .ser_ready(ser_ready),
    .ser_data(sd_l), .ser_last(sl_l), .busy(bz_l)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".m.ser_valid"}, sv_m, 1'b0);
    chk({tag, ".m.ser_data"},  sd_m, 1'b0);
    chk({tag, ".m.ser_last"},  sl_m, 1'b0);
    chk({tag, ".m.busy"},      bz_m, 1'b0);
    chk({tag, ".l.ser_valid"}, sv_l, 1'b0);
    chk({tag, ".l.ser_data"},  sd_l, 1'b0);
    chk({tag, ".l.ser_last"},  sl_l, 1'b0);
    chk({tag, ".l.busy"},      bz_l, 1'b0);
  endtask

  // One clock: check settled outputs at negedge, then apply the handshakes
  // that happened at the rising edge to the model.
  task automatic cycle();
    bit           exp_lr, pop, push;
    logic [W-1:0] d;
    @(negedge clk);
    exp_lr = (qm.size() == 0) || (ser_ready && qm.size() == 1);
    chk("m.load_ready", lr_m, exp_lr);
    chk("l.load_ready", lr_l, exp_lr);
    chk("m.ser_valid",  sv_m, qm.size() != 0);
    chk("l.ser_valid",  sv_l, ql.size() != 0);
    chk("m.busy",       bz_m, qm.size() != 0);
    chk("l.busy",       bz_l, ql.size() != 0);
    chk("m.ser_last",   sl_m, qm.size() == 1);
    chk("l.ser_last",   sl_l, ql.size() == 1);
    if (qm.size() != 0) chk("m.ser_data", sd_m, qm[0]);
    if (ql.size() != 0) chk("l.ser_data", sd_l, ql[0]);
    pop  = ser_ready && (qm.size() != 0);
    push = load_valid && exp_lr;
    d    = load_data;
    @(posedge clk);
    if (pop) begin
      void'(qm.pop_front());
      void'(ql.pop_front());
    end
    if (push) begin
      for (int i = W - 1; i >= 0; i--) qm.push_back(d[i]);
      for (int i = 0; i < W; i++)      ql.push_back(d[i]);
    end
    #1;
  endtask

  task automatic load(input logic [W-1:0] d);
    load_valid = 1'b1;
    load_data  = d;
    cycle();
    load_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    ser_ready  = 1'b0;

    // Reset state
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    ser_ready = 1'b1;
    cycle();

    // Full word at full rate, both bit orders
    load(8'hA5);
    repeat (10) cycle();
    load(8'h01);
    repeat (10) cycle();

    // Back-pressure after the second bit
    load(8'hF0);
    repeat (2) cycle();
    ser_ready = 1'b0;
    repeat (3) cycle();
    ser_ready = 1'b1;
    repeat (8) cycle();

    // Back-to-back words with load_valid held
    load_valid = 1'b1;
    load_data  = 8'h0F;
    cycle();
    load_data  = 8'hC3;
    repeat (8) cycle();
    load_valid = 1'b0;
    repeat (10) cycle();

    // Load attempted mid-word is ignored until the final bit
    load(8'h00);
    repeat (3) cycle();
    load_valid = 1'b1;
    load_data  = 8'hFF;
    repeat (5) cycle();
    load_valid = 1'b0;
    repeat (10) cycle();

    // Asynchronous reset mid-word
    load(8'h55);
    repeat (3) cycle();
    #2 rst = 1'b1;
    #1;
    chk_idle_outputs("async_rst");
    qm.delete();
    ql.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle();
    load(8'h80);
    repeat (10) cycle();

    // Randomized traffic with random back-pressure
    for (int n = 0; n < 400; n++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = W'($urandom);
      ser_ready  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    load_valid = 1'b0;
    ser_ready  = 1'b1;
    repeat (12) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
